// File: rtl/round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : round_ctrl
// Brief    : Round sequencer for the p12 / p6 permutation. Produces the round
//            index, the input-mux select, the state-register write enable and
//            a one-cycle completion pulse.
// Revision : 1.0  initial release
// ============================================================================
module round_ctrl #(
  parameter int ROUNDS_FULL = 12,
  parameter int ROUNDS_HALF = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic [3:0] round_o,
  output logic       init_sel_o,
  output logic       en_reg_state_o,
  output logic       done_o
);

  // Last round index of either permutation, and first round index of p6.
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_FULL - 1);
  localparam logic [3:0] HALF_START = 4'(ROUNDS_FULL - ROUNDS_HALF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // The selected mode is captured at acceptance purely through the starting
  // round value: p6 begins part-way through the index range and both modes
  // finish on the same last index, so no separate mode flag is needed to
  // steer the run once it has started.

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      round_o        <= 4'd0;
      ready_o        <= 1'b1;
      init_sel_o     <= 1'b0;
      en_reg_state_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state          <= RUN;
            round_o        <= mode_i ? HALF_START : 4'd0;
            ready_o        <= 1'b0;
            init_sel_o     <= 1'b1;
            en_reg_state_o <= 1'b1;
          end else begin
            round_o        <= 4'd0;
            ready_o        <= 1'b1;
            init_sel_o     <= 1'b0;
            en_reg_state_o <= 1'b0;
          end
        end

        RUN: begin
          // External state is only taken in the first round of a run.
          init_sel_o <= 1'b0;
          ready_o    <= 1'b0;
          // ">=" keeps the index from ever running past the last round.
          if (round_o >= LAST_ROUND) begin
            state          <= DONE;
            round_o        <= 4'd0;
            en_reg_state_o <= 1'b0;
            done_o         <= 1'b1;
          end else begin
            round_o        <= round_o + 4'd1;
            en_reg_state_o <= 1'b1;
            done_o         <= 1'b0;
          end
        end

        DONE: begin
          // Single-cycle completion pulse, then back to idle.
          state          <= IDLE;
          round_o        <= 4'd0;
          ready_o        <= 1'b1;
          init_sel_o     <= 1'b0;
          en_reg_state_o <= 1'b0;
          done_o         <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          round_o        <= 4'd0;
          ready_o        <= 1'b1;
          init_sel_o     <= 1'b0;
          en_reg_state_o <= 1'b0;
          done_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_ctrl
// Brief    : Self-checking bench for round_ctrl: cycle-by-cycle vector table
//            plus directed multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       ready;
  logic [3:0] round;
  logic       init_sel;
  logic       en_reg;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  round_ctrl #(.ROUNDS_FULL(12), .ROUNDS_HALF(6)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .mode_i         (mode),
    .ready_o        (ready),
    .round_o        (round),
    .init_sel_o     (init_sel),
    .en_reg_state_o (en_reg),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       mode;
    logic       ready;
    logic [3:0] round;
    logic       init_sel;
    logic       en;
    logic       done;
  } vec_t;

  vec_t vecs[80];
  int   nvec = 0;

  // Outputs packed as {ready, round[3:0], init_sel, en, done}.
  function automatic logic [7:0] pack(input logic r, input logic [3:0] rn,
                                      input logic i, input logic e, input logic d);
    return {r, rn, i, e, d};
  endfunction

  task automatic push(input logic r, input logic s, input logic m,
                      input logic er, input logic [3:0] ern, input logic ei,
                      input logic ee, input logic ed);
    vecs[nvec].rst      = r;
    vecs[nvec].start    = s;
    vecs[nvec].mode     = m;
    vecs[nvec].ready    = er;
    vecs[nvec].round    = ern;
    vecs[nvec].init_sel = ei;
    vecs[nvec].en       = ee;
    vecs[nvec].done     = ed;
    nvec++;
  endtask

  // Drive inputs, advance one clock, sample 1 ns after the edge.
  task automatic step(input logic r, input logic s, input logic m);
    rst   = r;
    start = s;
    mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = pack(ready, round, init_sel, en_reg, done);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ready=%b round=%0d init=%b en=%b done=%b, want ready=%b round=%0d init=%b en=%b done=%b",
               name, act[7], act[6:3], act[2], act[1], act[0],
               exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  initial begin
    int done_cnt;
    int rounds_seen;
    logic [3:0] r4;

    // ---------------- vector table ----------------
    // reset, reset with start (reset wins), idle
    push(1, 0, 0,  1, 4'd0, 0, 0, 0);
    push(1, 1, 1,  1, 4'd0, 0, 0, 0);
    push(0, 0, 0,  1, 4'd0, 0, 0, 0);
    // p12 run: accepted, rounds 0..11
    push(0, 1, 0,  0, 4'd0, 1, 1, 0);
    for (int k = 1; k < 12; k++)
      push(0, 0, k[0], 0, 4'(k), 0, 1, 0);   // mode wiggles, ignored
    push(0, 1, 1,  0, 4'd0, 0, 0, 1);        // DONE, start ignored
    push(0, 0, 1,  1, 4'd0, 0, 0, 0);        // IDLE
    // p6 run: rounds 6..11
    push(0, 1, 1,  0, 4'd6, 1, 1, 0);
    for (int k = 7; k < 12; k++)
      push(0, 0, 0, 0, 4'(k), 0, 1, 0);
    push(0, 0, 0,  0, 4'd0, 0, 0, 1);
    push(0, 0, 0,  1, 4'd0, 0, 0, 0);
    // p6 run reset during DONE
    push(0, 1, 1,  0, 4'd6, 1, 1, 0);
    for (int k = 7; k < 12; k++)
      push(0, 0, 1, 0, 4'(k), 0, 1, 0);
    push(0, 0, 0,  0, 4'd0, 0, 0, 1);
    push(1, 1, 0,  1, 4'd0, 0, 0, 0);
    push(0, 0, 0,  1, 4'd0, 0, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].mode);
      check($sformatf("vec%0d", i),
            pack(vecs[i].ready, vecs[i].round, vecs[i].init_sel, vecs[i].en, vecs[i].done));
    end

    // ---------------- start pulse + mode toggle mid p12 run ----------------
    step(0, 1, 0);
    check("p12x_r0", pack(0, 4'd0, 1, 1, 0));
    done_cnt    = 0;
    rounds_seen = 1;
    for (int k = 1; k < 16; k++) begin
      // round 5 is visible after step k=5; pulse start and flip mode next
      if (k == 6) step(0, 1, 1);
      else        step(0, 0, (k > 6) ? 1'b1 : 1'b0);
      if (k < 12) begin
        r4 = 4'(k);
        check($sformatf("p12x_r%0d", k), pack(0, r4, 0, 1, 0));
      end
      if (en_reg) rounds_seen++;
      if (done)   done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL p12x_done_count: got %0d, want 1", done_cnt);
    end
    n_cmp++;
    if (rounds_seen != 12) begin
      n_bad++;
      $display("FAIL p12x_round_count: got %0d, want 12", rounds_seen);
    end

    // ---------------- reset at round 7 ----------------
    step(0, 1, 0);
    begin
      int guard;
      guard = 0;
      while (round != 4'd7 && guard < 20) begin
        step(0, 0, 0);
        guard++;
      end
      n_cmp++;
      if (round != 4'd7) begin
        n_bad++;
        $display("FAIL abort_reach_r7: got round %0d, want 7", round);
      end
    end
    step(1, 0, 0);
    check("abort_after_rst", pack(1, 4'd0, 0, 0, 0));
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      if (done) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", done_cnt);
    end

    // ---------------- start held high, p6: 8-cycle period ----------------
    step(1, 1, 1);
    step(0, 1, 1);   // accepted on this edge
    check("held_first", pack(0, 4'd6, 1, 1, 0));
    done_cnt = 0;
    for (int k = 2; k <= 24; k++) begin
      int p;
      step(0, 1, 1);
      p = (k - 1) % 8;
      if (p < 6) begin
        r4 = 4'(6 + p);
        check($sformatf("held_k%0d", k), pack(0, r4, (p == 0) ? 1'b1 : 1'b0, 1, 0));
      end else if (p == 6) begin
        check($sformatf("held_k%0d", k), pack(0, 4'd0, 0, 0, 1));
      end else begin
        check($sformatf("held_k%0d", k), pack(1, 4'd0, 0, 0, 0));
      end
      if (done) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 3) begin
      n_bad++;
      $display("FAIL held_done_count: got %0d, want 3", done_cnt);
    end
    step(1, 0, 0);
    check_bit("final_ready", ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
